// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: decode-stage controller for the immediate extender.
//
// Accepts fetched instructions over a valid/ready handshake. Up to two instructions are held:
// the registered output slot (id_*) and one skid slot. Each instruction is decoded when it enters
// the output slot, so imm_src and the type flags always belong to the instruction on id_instr.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   if_valid/if_ready          fetch-side handshake; if_ready is high unless the skid slot is full
//   if_instr, if_pc            fetched instruction and its PC
//   flush                      redirect; drops every held instruction and any same-cycle input
//   id_valid/id_ready          ID/EX-side handshake; id_ready low stalls the output
//   id_instr, id_pc            registered instruction and PC (NOP / RESET_PC when empty)
//   imm_src                    00=I 01=S 10=B 11=J immediate extender select
//   uses_imm, u_type, illegal  decode flags, all zero when id_valid is low
module id_imm_ctrl #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [1:0]      imm_src,
  output logic            uses_imm,
  output logic            u_type,
  output logic            illegal
);

  localparam logic [XLEN-1:0] Nop = 32'h0000_0013;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] imm_src;
    logic       uses_imm;
    logic       u_type;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] opcode);
    dec_t dec;
    dec = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec.imm_src  = ImmI;
        dec.uses_imm = 1'b1;
      end
      7'b0100011: begin
        dec.imm_src  = ImmS;
        dec.uses_imm = 1'b1;
      end
      7'b1100011: begin
        dec.imm_src  = ImmB;
        dec.uses_imm = 1'b1;
      end
      7'b1101111: begin
        dec.imm_src  = ImmJ;
        dec.uses_imm = 1'b1;
      end
      // LUI/AUIPC: the U immediate is assembled downstream, not by the extender.
      7'b0110111, 7'b0010111: dec.u_type = 1'b1;
      7'b0110011:             dec = '0;
      default:                dec.illegal = 1'b1;
    endcase
    return dec;
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  dec_t            out_dec_q, out_dec_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;

  logic in_xfer;
  logic out_xfer;

  assign if_ready = (state_q != StTwo);
  assign id_valid = (state_q != StEmpty);
  assign in_xfer  = if_valid & if_ready;
  assign out_xfer = id_valid & id_ready;

  always_comb begin
    state_d      = state_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_dec_d    = out_dec_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          out_instr_d = if_instr;
          out_pc_d    = if_pc;
          out_dec_d   = decode(if_instr[6:0]);
          state_d     = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          out_instr_d = if_instr;
          out_pc_d    = if_pc;
          out_dec_d   = decode(if_instr[6:0]);
        end else if (out_xfer) begin
          // Going empty: return outputs to their idle values so flags read zero.
          out_instr_d = Nop;
          out_pc_d    = RESET_PC;
          out_dec_d   = '0;
          state_d     = StEmpty;
        end else if (in_xfer) begin
          skid_instr_d = if_instr;
          skid_pc_d    = if_pc;
          state_d      = StTwo;
        end
      end
      StTwo: begin
        // if_ready is low here, so only the skid entry can advance.
        if (out_xfer) begin
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          out_dec_d   = decode(skid_instr_q[6:0]);
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush overrides everything above, including a same-cycle input transfer.
    if (flush) begin
      state_d     = StEmpty;
      out_instr_d = Nop;
      out_pc_d    = RESET_PC;
      out_dec_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      out_instr_q  <= Nop;
      out_pc_q     <= RESET_PC;
      out_dec_q    <= '0;
      skid_instr_q <= Nop;
      skid_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_dec_q    <= out_dec_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign id_instr = out_instr_q;
  assign id_pc    = out_pc_q;
  assign imm_src  = out_dec_q.imm_src;
  assign uses_imm = out_dec_q.uses_imm;
  assign u_type   = out_dec_q.u_type;
  assign illegal  = out_dec_q.illegal;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Directed self-checking bench for id_imm_ctrl.
module tb_id_imm_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  imm_src;
  logic        uses_imm;
  logic        u_type;
  logic        illegal;

  int n_checks;
  int n_errors;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h00A0_0093;
  localparam logic [31:0] SW    = 32'h0011_2223;
  localparam logic [31:0] BEQ   = 32'h0020_8463;
  localparam logic [31:0] JAL   = 32'h0080_00EF;
  localparam logic [31:0] LUI   = 32'h1234_50B7;
  localparam logic [31:0] BAD   = 32'h0000_007F;

  id_imm_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .flush    (flush),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_instr (id_instr),
    .id_pc    (id_pc),
    .imm_src  (imm_src),
    .uses_imm (uses_imm),
    .u_type   (u_type),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".id_valid"}, {31'b0, id_valid}, 32'd0);
    check({tag, ".if_ready"}, {31'b0, if_ready}, 32'd1);
    check({tag, ".id_instr"}, id_instr, NOP);
    check({tag, ".id_pc"}, id_pc, 32'h0);
    check({tag, ".flags"}, {27'b0, imm_src, uses_imm, u_type, illegal}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    flush    = 1'b0;
    id_ready = 1'b0;

    // Reset values
    step();
    step();
    check_idle("reset");
    rst_n = 1'b1;

    // 1: addi, one cycle latency
    id_ready = 1'b1;
    offer(ADDI, 32'h100);
    step();
    check("t1.id_valid", {31'b0, id_valid}, 32'd1);
    check("t1.id_instr", id_instr, ADDI);
    check("t1.id_pc", id_pc, 32'h100);
    check("t1.imm_src", {30'b0, imm_src}, 32'd0);
    check("t1.uses_imm", {31'b0, uses_imm}, 32'd1);

    // 2: S, B, J back to back with no bubbles
    offer(SW, 32'h104);
    step();
    check("t2.s.instr", id_instr, SW);
    check("t2.s.imm_src", {30'b0, imm_src}, 32'd1);
    offer(BEQ, 32'h108);
    step();
    check("t2.b.valid", {31'b0, id_valid}, 32'd1);
    check("t2.b.imm_src", {30'b0, imm_src}, 32'd2);
    offer(JAL, 32'h10C);
    step();
    check("t2.j.imm_src", {30'b0, imm_src}, 32'd3);
    check("t2.j.pc", id_pc, 32'h10C);
    check("t2.j.uses_imm", {31'b0, uses_imm}, 32'd1);
    if_valid = 1'b0;
    step();
    check_idle("t2.drain");

    // 3: stall fills skid, then in-order drain
    id_ready = 1'b0;
    offer(ADDI, 32'h200);
    step();
    offer(SW, 32'h204);
    step();
    check("t3.if_ready", {31'b0, if_ready}, 32'd0);
    check("t3.hold.instr", id_instr, ADDI);
    offer(BEQ, 32'h208);
    step();
    check("t3.stall.instr", id_instr, ADDI);
    check("t3.stall.pc", id_pc, 32'h200);
    check("t3.stall.imm_src", {30'b0, imm_src}, 32'd0);
    if_valid = 1'b0;
    id_ready = 1'b1;
    step();
    check("t3.second.instr", id_instr, SW);
    check("t3.second.pc", id_pc, 32'h204);
    check("t3.second.imm_src", {30'b0, imm_src}, 32'd1);
    check("t3.second.if_ready", {31'b0, if_ready}, 32'd1);
    step();
    check("t3.empty.valid", {31'b0, id_valid}, 32'd0);

    // 4: flush in TWO with a same-cycle input
    id_ready = 1'b0;
    offer(ADDI, 32'h300);
    step();
    offer(SW, 32'h304);
    step();
    check("t4.full", {31'b0, if_ready}, 32'd0);
    offer(JAL, 32'h308);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    check_idle("t4.flush");
    id_ready = 1'b1;
    step();
    step();
    check("t4.dropped.valid", {31'b0, id_valid}, 32'd0);
    check("t4.dropped.instr", id_instr, NOP);

    // 5: LUI then an illegal opcode, both flow through
    offer(LUI, 32'h400);
    step();
    check("t5.lui.valid", {31'b0, id_valid}, 32'd1);
    check("t5.lui.flags", {27'b0, imm_src, uses_imm, u_type, illegal}, 32'b00010);
    offer(BAD, 32'h404);
    step();
    check("t5.bad.valid", {31'b0, id_valid}, 32'd1);
    check("t5.bad.instr", id_instr, BAD);
    check("t5.bad.flags", {27'b0, imm_src, uses_imm, u_type, illegal}, 32'b00001);
    if_valid = 1'b0;
    step();
    check("t5.drain.illegal", {31'b0, illegal}, 32'd0);

    // 6: asynchronous reset mid-cycle while in TWO
    id_ready = 1'b0;
    offer(BEQ, 32'h500);
    step();
    offer(JAL, 32'h504);
    step();
    if_valid = 1'b0;
    check("t6.full", {31'b0, if_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t6.async");
    step();
    rst_n = 1'b1;
    id_ready = 1'b1;
    step();
    check("t6.after.valid", {31'b0, id_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
